// File: rtl/inv_add_round_key.sv
// inv_add_round_key: AES inverse-cipher AddRoundKey stage with round counter and one-deep output register
// Ports: clk/rst (async, active-high); i_start begins a block in IDLE;
//        i_data/i_valid/o_ready input handshake; i_round_key keyed by o_round_num;
//        o_data/o_valid/i_ready output handshake; o_mix_en routes through inv_mix_columns;
//        o_last flags the plaintext; o_busy is high while a block is in progress.
module inv_add_round_key #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [127:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_round_key,
    output logic [3:0]   o_round_num,
    output logic [127:0] o_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_mix_en,
    output logic         o_last,
    output logic         o_busy
);
    localparam logic [3:0] NR = 4'(NUM_ROUNDS);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state, state_nxt;
    logic [3:0] round;
    logic       accept;

    assign o_busy      = state == ACTIVE;
    // Single output register: it may refill in the same cycle it drains.
    assign o_ready     = o_busy && (!o_valid || i_ready);
    assign accept      = i_valid && o_ready;
    assign o_round_num = round;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = i_start ? ACTIVE : IDLE;
        else               state_nxt = (accept && round == 4'd0) ? IDLE : ACTIVE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round    <= 4'd0;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_mix_en <= 1'b0;
            o_last   <= 1'b0;
        end else if (accept) begin
            o_data   <= i_data ^ i_round_key;
            o_valid  <= 1'b1;
            // Only the initial (round NR) and final (round 0) adds skip inv_mix_columns.
            o_mix_en <= round != 4'd0 && round != NR;
            o_last   <= round == 4'd0;
            round    <= round == 4'd0 ? 4'd0 : round - 4'd1;
        end else begin
            if (o_valid && i_ready) o_valid <= 1'b0;
            if (state == IDLE && i_start) round <= NR;
        end
    end
endmodule

// File: tb/tb_inv_add_round_key.sv
// tb_inv_add_round_key: randomized self-checking bench for inv_add_round_key against a block-level model
// Ports: none; drives the DUT with a key store indexed by o_round_num and checks every cycle.
module tb_inv_add_round_key;
    localparam int NR = 10;

    logic         tb_clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_start = 1'b0;
    logic [127:0] i_data = '0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [127:0] i_round_key;
    logic [3:0]   o_round_num;
    logic [127:0] o_data;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic         o_mix_en;
    logic         o_last;
    logic         o_busy;

    logic [127:0] key [16];
    int n_checks = 0;
    int n_err = 0;

    // Block-level model: m_acc counts accepts already taken in the current block.
    bit           m_busy = 0;
    int           m_acc = 0;
    bit           m_valid = 0;
    logic [127:0] m_data = '0;
    bit           m_mix = 0;
    bit           m_last = 0;
    bit           m_rdy, m_take;

    inv_add_round_key #(.NUM_ROUNDS(NR)) dut (
        .clk(tb_clk), .rst(rst), .i_start(i_start), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .i_round_key(i_round_key), .o_round_num(o_round_num),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_mix_en(o_mix_en),
        .o_last(o_last), .o_busy(o_busy)
    );

    assign i_round_key = key[o_round_num];

    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge tb_clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_acc = 0; m_valid = 0; m_data = '0; m_mix = 0; m_last = 0;
        end else begin
            m_rdy  = m_busy && (!m_valid || i_ready);
            m_take = i_valid && m_rdy;
            if (m_take) begin
                m_data  = i_data ^ key[NR - m_acc];
                m_valid = 1;
                m_mix   = m_acc >= 1 && m_acc <= NR - 1;
                m_last  = m_acc == NR;
                m_acc++;
                if (m_acc == NR + 1) begin
                    m_busy = 0;
                    m_acc  = 0;
                end
            end else begin
                if (m_valid && i_ready) m_valid = 0;
                if (!m_busy && i_start) begin
                    m_busy = 1;
                    m_acc  = 0;
                end
            end
        end
    end

    always @(negedge tb_clk) begin
        chk1("busy", o_busy, m_busy);
        chk1("ready", o_ready, m_busy && (!m_valid || i_ready));
        chk4("round", o_round_num, m_busy ? 4'(NR - m_acc) : 4'd0);
        chk1("valid", o_valid, m_valid);
        if (m_valid) begin
            chk("data", o_data, m_data);
            chk1("mix_en", o_mix_en, m_mix);
            chk1("last", o_last, m_last);
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) key[i] = rnd128();
        key[NR] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        key[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rst = 1'b1;
        step();
        step();
        chk("rst_data", o_data, 128'h0);
        chk1("rst_valid", o_valid, 1'b0);
        chk1("rst_ready", o_ready, 1'b0);
        chk1("rst_busy", o_busy, 1'b0);
        chk4("rst_round", o_round_num, 4'd0);
        rst = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_data = rnd128();
        repeat (3) step();
        chk1("idle_no_accept", o_valid, 1'b0);
        i_valid = 1'b0;

        // FIPS-197 C.1 block with literal first and last round
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk1("start_busy", o_busy, 1'b1);
        chk1("start_ready", o_ready, 1'b1);
        i_valid = 1'b1;
        i_data = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        step();
        chk("c1_data", o_data, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
        chk1("c1_mix", o_mix_en, 1'b0);
        chk1("c1_last", o_last, 1'b0);
        chk4("c1_round", o_round_num, 4'd9);
        for (int k = 0; k < NR - 1; k++) begin
            i_data = rnd128();
            step();
            chk1("mid_mix", o_mix_en, 1'b1);
        end
        i_data = 128'h00102030405060708090a0b0c0d0e0f0;
        step();
        chk("final_data", o_data, 128'h00112233445566778899aabbccddeeff);
        chk1("final_last", o_last, 1'b1);
        chk1("final_mix", o_mix_en, 1'b0);
        chk1("final_idle", o_busy, 1'b0);
        i_valid = 1'b0;
        step();
        chk1("final_drained", o_valid, 1'b0);

        // backpressure, then i_start held through the rest of the block
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_valid = 1'b1;
        i_data = rnd128();
        step();
        i_ready = 1'b0;
        i_data = rnd128();
        repeat (3) begin
            step();
            chk1("bp_ready", o_ready, 1'b0);
            chk1("bp_valid", o_valid, 1'b1);
        end
        i_ready = 1'b1;
        step();
        chk4("bp_round", o_round_num, 4'd8);
        i_start = 1'b1;
        for (int k = 0; k < NR - 1; k++) begin
            i_data = rnd128();
            step();
        end
        i_start = 1'b0;
        chk1("ign_start_last", o_last, 1'b1);
        chk1("ign_start_idle", o_busy, 1'b0);
        i_valid = 1'b0;
        step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk4("restart_round", o_round_num, 4'(NR));
        i_valid = 1'b1;
        repeat (NR + 1) begin
            i_data = rnd128();
            step();
        end
        i_valid = 1'b0;
        step();

        // reset after 5 accepts, then a clean block
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_valid = 1'b1;
        repeat (5) begin
            i_data = rnd128();
            step();
        end
        #2 rst = 1'b1;
        #1;
        chk1("mid_rst_valid", o_valid, 1'b0);
        chk4("mid_rst_round", o_round_num, 4'd0);
        chk1("mid_rst_busy", o_busy, 1'b0);
        chk1("mid_rst_ready", o_ready, 1'b0);
        chk1("mid_rst_last", o_last, 1'b0);
        chk("mid_rst_data", o_data, 128'h0);
        rst = 1'b0;
        i_valid = 1'b0;
        step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_valid = 1'b1;
        repeat (NR + 1) begin
            i_data = rnd128();
            step();
        end
        chk1("post_rst_last", o_last, 1'b1);
        chk1("post_rst_idle", o_busy, 1'b0);
        i_valid = 1'b0;
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst     = $urandom_range(0, 499) == 0;
            i_start = $urandom_range(0, 9) == 0;
            i_valid = $urandom_range(0, 9) < 7;
            i_ready = $urandom_range(0, 9) < 7;
            i_data  = rnd128();
            step();
        end
        rst = 1'b0;
        i_start = 1'b0;
        i_valid = 1'b0;
        step();
        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/inv_add_round_key.md
# inv_add_round_key

Sequential AddRoundKey stage of the AES inverse cipher. It sits directly upstream of `inv_mix_columns`: it XORs each incoming 128-bit state with the round key for the current round and tracks the round count from NUM_ROUNDS down to 0. It registers the result behind a valid/ready handshake. It tags each output with whether it must pass through `inv_mix_columns` (rounds NUM_ROUNDS-1..1) or bypass it (the initial and final rounds).

## Interface
- NUM_ROUNDS, 10, number of cipher rounds (10/12/14 for AES-128/192/256); the counter is 4 bits wide.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse that begins a new block; honoured only in IDLE.
- i_data  in  128  incoming state; byte 0 is in [127:120].
- i_valid  in  1  i_data is valid.
- o_ready  out  1  stage accepts i_data this cycle.
- i_round_key  in  128  key for the round on o_round_num; supplied combinationally by the key store.
- o_round_num  out  4  round currently being keyed (NUM_ROUNDS..0).
- o_data  out  128  registered i_data ^ i_round_key.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  downstream accepts o_data.
- o_mix_en  out  1  o_data must go through inv_mix_columns.
- o_last  out  1  o_data is the plaintext (round 0 result).
- o_busy  out  1  block in progress (state ACTIVE).

## Operation
- States: IDLE, ACTIVE.
- IDLE:
  - o_ready=0.
  - i_start=1 → ACTIVE, and round counter loads NUM_ROUNDS.
- ACTIVE:
  - o_ready = !o_valid || i_ready. This is a single output register; it refills in the same cycle it drains.
  - An accept (i_valid && o_ready) does all of the following:
    - o_data ← i_data ^ i_round_key.
    - o_valid ← 1.
    - o_mix_en ← (round ≥ 1 && round ≤ NUM_ROUNDS-1).
    - o_last ← (round == 0).
    - If round == 0: → IDLE. Otherwise round decrements.
- Output drain: o_valid && i_ready with no accept in the same cycle → o_valid ← 0.
- Backpressure: o_valid && !i_ready → o_data, o_mix_en and o_last hold stable.
- A block is exactly NUM_ROUNDS+1 accepts:
  - The first accept is the initial key add, with o_mix_en=0.
  - The middle NUM_ROUNDS-1 accepts have o_mix_en=1.
  - The last accept has o_mix_en=0 and o_last=1.
- i_start while ACTIVE is ignored, including in the cycle of the final accept. A new block needs i_start in a later IDLE cycle.
- i_start and the previous block's last output draining in the same cycle are both allowed.
- i_valid in IDLE is ignored; nothing is consumed.
- o_round_num = round counter register. It reads 0 in IDLE after reset or after completion.
- Reset mid-block discards the block. The pending output is dropped with no partial o_last.

## Timing
- Reset values: state IDLE, round 0, o_data 0, o_valid 0, o_mix_en 0, o_last 0, o_busy 0, o_ready 0.
- i_start in cycle N → o_busy=1 and o_ready=1 in N+1. The first accept is possible in N+1.
- Latency: 1 cycle from accept to o_valid.
- Throughput: 1 accept per cycle while i_ready=1.
- o_round_num changes only on the clock edge after an accept. The key store has one full cycle to present i_round_key.
- o_ready depends combinationally on i_ready and registered state only, never on i_valid.

## Test plan
- **Reset:** assert rst mid-clock → every output is at its reset value immediately, with no clock edge needed. After deassert, i_valid=1 with no i_start → nothing is accepted and o_valid stays 0.
- **FIPS-197 C.1 initial round:** i_start, then i_data=69c4e0d86a7b0430d8cdb78070b4c55a with i_round_key=13111d7fe3944a17f307a78b4d2b30c5 → o_data=7ad5fda789ef4e272bca100b3d9ff59f, o_mix_en=0, o_last=0, o_round_num=9 next cycle.
- **Full block, i_ready=1:** 11 consecutive accepts with keys indexed by o_round_num.
  - o_mix_en=1 on outputs 2..10 only.
  - Output 11: i_data=00102030405060708090a0b0c0d0e0f0, key 000102030405060708090a0b0c0d0e0f → o_data=00112233445566778899aabbccddeeff, o_last=1, then IDLE.
- **Backpressure:** hold i_ready=0 for 3 cycles after an accept → o_ready=0 and o_data stable. Releasing i_ready → next accept lands in the same cycle as the drain.
- **i_start while ACTIVE and in the final-accept cycle:** round sequence unaffected and o_busy drops after the final accept. A later i_start in IDLE restarts at round NUM_ROUNDS.
- **Reset after 5 accepts:** o_valid=0 and o_round_num=0. A fresh block then runs cleanly to o_last after 11 accepts.
